// File: rtl/board_pkg.sv
// Board-level constants shared by the input conditioning logic and game_top.
// Key debouncer timing defaults are derived from the 25.2 MHz pixel clock.
package board_pkg;

    localparam int KEYS_W            = 4;
    localparam int PIXEL_CLK_HZ      = 25_200_000;
    localparam int DEBOUNCE_MS       = 10;
    localparam int REPEAT_DELAY_MS   = 250;
    localparam int REPEAT_PERIOD_MS  = 100;

    localparam int DEBOUNCE_CYCLES_DEF = PIXEL_CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int REPEAT_DELAY_DEF    = PIXEL_CLK_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int REPEAT_PERIOD_DEF   = PIXEL_CLK_HZ / 1000 * REPEAT_PERIOD_MS;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } key_edge_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-FF synchroniser, stability-counter debouncer and press/release strobes.
// Auto-repeat of the press strobe is built only when KEYS_AUTOREPEAT_EN is defined.
module key_debounce_cell
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_i,
    output logic key_o,
    output logic pressed_o,
    output logic released_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_debounce_cell: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_debounce_cell: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic          meta;
    logic          sync;
    logic          level;
    logic [CW-1:0] cnt;
    key_edge_e     stb;
    logic          accept;
    logic          rep_stb;

    assign accept = (sync != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            stb   <= EDGE_NONE;
        end else begin
            meta <= key_i;
            sync <= meta;
            stb  <= EDGE_NONE;
            if (sync == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync;
                cnt   <= '0;
                stb   <= sync ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef KEYS_AUTOREPEAT_EN
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [RW-1:0] rcnt;
    logic          rep_phase;

    // rcnt restarts after every strobe; rep_phase picks the initial delay or the period
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
            rep_stb   <= 1'b0;
        end else begin
            rep_stb <= 1'b0;
            if (!level || accept) begin
                rcnt      <= '0;
                rep_phase <= 1'b0;
            end else if (!rep_phase && rcnt == RW'(REPEAT_DELAY - 1)) begin
                rcnt      <= '0;
                rep_phase <= 1'b1;
                rep_stb   <= 1'b1;
            end else if (rep_phase && rcnt == RW'(REPEAT_PERIOD - 1)) begin
                rcnt    <= '0;
                rep_stb <= 1'b1;
            end else if (rcnt != '1) begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end
`else
    assign rep_stb = 1'b0;
`endif

    assign key_o      = level;
    assign pressed_o  = (stb == EDGE_RISE) || rep_stb;
    assign released_o = (stb == EDGE_FALL);

endmodule

// File: rtl/keys_debouncer.sv
// Debounces KEYS_W raw push-buttons into levels plus press/release strobes.
// Define KEYS_AUTOREPEAT_EN to add auto-repeat press strobes while a key is held.
module keys_debouncer
    import board_pkg::*;
#(
    parameter int KEYS_W          = board_pkg::KEYS_W,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [KEYS_W-1:0] keys_i,
    output logic [KEYS_W-1:0] keys_o,
    output logic [KEYS_W-1:0] pressed_o,
    output logic [KEYS_W-1:0] released_o
);

    for (genvar i = 0; i < KEYS_W; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_cell (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .key_i      (keys_i[i]),
            .key_o      (keys_o[i]),
            .pressed_o  (pressed_o[i]),
            .released_o (released_o[i])
        );
    end

endmodule

// File: tb/tb_keys_debouncer.sv
// Scoreboard bench for keys_debouncer: a sliding-window reference predicts outputs per cycle.
// Build with KEYS_AUTOREPEAT_EN defined to also predict auto-repeat strobes.
module tb_keys_debouncer;

    localparam int KW = 2;
    localparam int DC = 8;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int HW = DC + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] keys = '0;
    logic [KW-1:0] keys_o;
    logic [KW-1:0] pressed;
    logic [KW-1:0] released;

    always #5 clk = ~clk;

    keys_debouncer #(
        .KEYS_W          (KW),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .keys_i     (keys),
        .keys_o     (keys_o),
        .pressed_o  (pressed),
        .released_o (released)
    );

    typedef struct {
        string           tag;
        logic [3*KW-1:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned passes = 0;

    logic [HW-1:0] hist [KW];
    logic          lvl  [KW];
    int            held [KW];

    task automatic check_eq(input string tag, input logic [3*KW-1:0] got, input logic [3*KW-1:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got {keys,pressed,released}=%b expected %b at %0t", tag, got, want, $time);
    endtask

    // Outputs flip once the input, seen two flops late, has differed from the level for DC samples.
    task automatic step(input string tag, input logic r, input logic [KW-1:0] k);
        logic [KW-1:0] eo, ep, er;
        @(negedge clk);
        rst_n = r;
        keys  = k;
        for (int i = 0; i < KW; i++) begin
            ep[i] = 1'b0;
            er[i] = 1'b0;
            if (!r) begin
                hist[i] = '0;
                lvl[i]  = 1'b0;
                held[i] = 0;
            end else begin
                hist[i] = {hist[i][HW-2:0], k[i]};
                if (hist[i][HW-1:2] == {DC{~lvl[i]}}) begin
                    lvl[i]  = ~lvl[i];
                    ep[i]   = lvl[i];
                    er[i]   = ~lvl[i];
                    held[i] = 0;
                end
`ifdef KEYS_AUTOREPEAT_EN
                else if (lvl[i]) begin
                    held[i]++;
                    if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0)) ep[i] = 1'b1;
                end
`endif
            end
            eo[i] = lvl[i];
        end
        sb.push_back('{tag, {eo, ep, er}});
    endtask

    task automatic run(input string tag, input logic r, input logic [KW-1:0] k, input int n);
        for (int j = 0; j < n; j++) step(tag, r, k);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq(e.tag, {keys_o, pressed, released}, e.val);
                check_eq({e.tag, "_excl"}, {{(2*KW){1'b0}}, pressed & released}, '0);
            end
        end
    end

    initial begin
        for (int i = 0; i < KW; i++) begin
            hist[i] = '0;
            lvl[i]  = 1'b0;
            held[i] = 0;
        end

        run("reset",      1'b0, 2'b11, 5);
        run("held_rst",   1'b1, 2'b11, 15);
        run("rel_both",   1'b1, 2'b00, 15);

        run("press0",     1'b1, 2'b01, 15);
        run("release0",   1'b1, 2'b00, 15);

        for (int j = 0; j < 10; j++) run("bounce", 1'b1, (j % 2 == 0) ? 2'b01 : 2'b00, 3);
        run("bounce_hold", 1'b1, 2'b01, 15);
        run("bounce_rel",  1'b1, 2'b00, 15);

        run("glitch7",    1'b1, 2'b10, 7);
        run("glitch7_q",  1'b1, 2'b00, 15);
        run("pulse8",     1'b1, 2'b10, 8);
        run("pulse8_q",   1'b1, 2'b00, 20);

        run("midcnt",     1'b1, 2'b01, 7);
        run("midrst",     1'b0, 2'b01, 3);
        run("after_rst",  1'b1, 2'b01, 15);
        run("after_rel",  1'b1, 2'b00, 15);

        run("hold",       1'b1, 2'b01, 69);
        run("hold_rel",   1'b1, 2'b00, 15);

        run("idle",       1'b1, 2'b00, 3);
        @(posedge clk);
        #4;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
